// File: rtl/nibble_add_sequencer.sv
// Wide adder built from one 4-bit ripple adder reused one nibble per cycle, LSB first.
// Optional subtract mode (op_sub port) is enabled with `define NIBBLE_SEQ_SUB_EN.

module ripple_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CI,
    output logic [3:0] SUM,
    output logic       CO
);
    logic [4:0] w_c;

    always_comb begin
        w_c    = '0;
        SUM    = '0;
        w_c[0] = CI;
        for (int i = 0; i < 4; i++) begin
            SUM[i]   = A[i] ^ B[i] ^ w_c[i];
            w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
        CO = w_c[4];
    end
endmodule

module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 op_ci,
`ifdef NIBBLE_SEQ_SUB_EN
    input  logic                 op_sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 co,
    output logic                 busy
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_co;
    logic [IDX_W-1:0]   r_idx;
    logic               r_sub;
    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_add_a;
    logic [3:0]         w_add_b;
    logic               w_add_ci;
    logic [3:0]         w_add_sum;
    logic               w_add_co;
    logic               w_sub_req;

`ifdef NIBBLE_SEQ_SUB_EN
    assign w_sub_req = op_sub;
`else
    assign w_sub_req = 1'b0;
`endif

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = S_RUN;
            S_RUN:  if (w_last) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    // Adder sees zeros outside RUN; B is inverted for subtraction
    always_comb begin
        w_add_a  = 4'h0;
        w_add_b  = 4'h0;
        w_add_ci = 1'b0;
        if (r_state == S_RUN) begin
            w_add_a  = r_a[4*r_idx +: 4];
            w_add_b  = r_b[4*r_idx +: 4] ^ {4{r_sub}};
            w_add_ci = r_carry;
        end
    end

    ripple_adder u_adder (
        .A   (w_add_a),
        .B   (w_add_b),
        .CI  (w_add_ci),
        .SUM (w_add_sum),
        .CO  (w_add_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_idx   <= '0;
            r_sub   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= w_sub_req;
            r_carry <= w_sub_req ? 1'b1 : op_ci;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[4*r_idx +: 4] <= w_add_sum;
            r_carry             <= w_add_co;
            if (w_last) r_co  <= w_add_co;
            else        r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign sum = r_sum;
    assign co  = r_co;
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench for nibble_add_sequencer (NIBBLES=4): vector table, corner sequences, random ops.
`timescale 1ns/1ps
module tb_nibble_add_sequencer;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         op_ci = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         co;
    logic         busy;

    int errors = 0;
    int checks = 0;

    nibble_add_sequencer #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ci     (op_ci),
`ifdef NIBBLE_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] exp_sum;
        logic         exp_co;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic over W+1 bits
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic ci, input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        return r;
    endfunction

    // Issue one op, wait for result, hold out_ready low for 'stall' cycles, then handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sub, input int stall,
                         output logic [W-1:0] s, output logic c, output int lat);
        int n;
        op_a = a; op_b = b; op_ci = ci; op_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        if (n >= 100) check("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); op_ci = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        if (lat >= 100) check("result_timeout", 0, 1);
        repeat (stall) tick();
        s = sum; c = co;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t         vecs[$];
        logic [W-1:0] s;
        logic         c;
        logic [W-1:0] hold_s;
        logic         hold_c;
        logic [W:0]   m;
        int           lat;
        int           nb;
        int           n;

        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});

        // Reset state
        #2;
        check("rst_sum", 32'(sum), 0);
        check("rst_co", 32'(co), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 1);

        // Table vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, 0, s, c, lat);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_co", i), 32'(c), 32'(vecs[i].exp_co));
            check($sformatf("vec%0d_lat", i), lat, N);
        end

        // Busy spans RUN plus one DONE cycle when out_ready is already high
        op_a = 16'h1234; op_b = 16'h4321; op_ci = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        nb = 0; n = 0;
        while (busy && n < 50) begin
            if (out_valid) check("busy_seq_sum", 32'(sum), 32'h5555);
            nb++; tick(); n++;
        end
        check("busy_cycles", nb, N + 1);
        out_ready = 1'b0;

        // Backpressure: result stable, input ignored while DONE
        op_a = 16'h0101; op_b = 16'h0202; op_ci = 1'b0; in_valid = 1'b1;
        while (!in_ready) tick();
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        hold_s = sum; hold_c = co;
        check("bp_sum", 32'(hold_s), 32'h0303);
        for (int k = 0; k < 6; k++) begin
            in_valid = (k == 2); op_a = 16'hAAAA; op_b = 16'h5555; op_ci = 1'b1;
            tick();
            check("bp_stable_sum", 32'(sum), 32'(hold_s));
            check("bp_stable_co", 32'(co), 32'(hold_c));
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 1);
        check("bp_release_sum_kept", 32'(sum), 32'h0303);
        check("bp_release_busy", 32'(busy), 0);

        // Back-to-back with in_valid held high
        op_a = 16'h0001; op_b = 16'h0002; op_ci = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        op_a = 16'h7FFF; op_b = 16'h0001;
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("b2b_1_sum", 32'(sum), 32'h0003);
        check("b2b_1_co", 32'(co), 0);
        check("b2b_1_lat", lat, N);
        tick();
        check("b2b_idle", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("b2b_2_sum", 32'(sum), 32'h8000);
        check("b2b_2_co", 32'(co), 0);
        check("b2b_2_lat", lat, N);
        tick();
        out_ready = 1'b0;

        // Reset in the middle of RUN
        op_a = 16'h1111; op_b = 16'h2222; op_ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_sum", 32'(sum), 0);
        check("midrst_co", 32'(co), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        tick();
        rst_n = 1'b1;
        nb = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (out_valid) nb++; end
        check("midrst_no_out_valid", nb, 0);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1, s, c, lat);
        check("post_rst_sum", 32'(s), 32'h0100);
        check("post_rst_co", 32'(c), 0);

`ifdef NIBBLE_SEQ_SUB_EN
        do_op(16'h0005, 16'h0003, 1'b0, 1'b1, 0, s, c, lat);
        check("sub1_sum", 32'(s), 32'h0002);
        check("sub1_co", 32'(c), 1);
        do_op(16'h0003, 16'h0005, 1'b0, 1'b1, 0, s, c, lat);
        check("sub2_sum", 32'(s), 32'hFFFE);
        check("sub2_co", 32'(c), 0);
        do_op(16'h0005, 16'h0003, 1'b1, 1'b1, 0, s, c, lat);
        check("sub_ci_ignored_sum", 32'(s), 32'h0002);
        check("sub_ci_ignored_co", 32'(c), 1);
        check("sub_lat", lat, N);
`endif

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rci;
            logic         rsub;
            ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
`ifdef NIBBLE_SEQ_SUB_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            m = model(ra, rb, rci, rsub);
            do_op(ra, rb, rci, rsub, $urandom_range(0, 3), s, c, lat);
            check("rand_sum", 32'(s), 32'(m[W-1:0]));
            check("rand_co", 32'(c), 32'(m[W]));
            check("rand_lat", lat, N);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
